// File: rtl/dmem_lsu_ctrl.sv
// Data-memory load/store controller between the MEM stage and a byte-enabled
// synchronous SRAM. It accepts one request per handshake, drives a single
// registered SRAM access, and returns extended load data or an error code.
//
// Handshake: a request transfers on a rising edge where req_valid && req_ready.
// req_ready is high only in IDLE. The producer holds req_valid and its fields
// stable until the transfer. resp_valid is a single-cycle pulse with no
// back-pressure. The consumer must take it when it appears.
module dmem_lsu_ctrl #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_write,
  input  logic [2:0]                 req_funct3,
  input  logic [ADDR_W-1:0]          req_addr,
  input  logic [XLEN-1:0]            req_wdata,
  output logic                       resp_valid,
  output logic [XLEN-1:0]            resp_rdata,
  output logic [1:0]                 resp_err,
  output logic                       OE_dm,
  output logic [XLEN/8-1:0]          WEB_dm,
  output logic [ADDR_W-$clog2(XLEN/8)-1:0] A_dm,
  output logic [XLEN-1:0]            DI_dm,
  input  logic [XLEN-1:0]            DO_dm
);

  localparam int NB  = XLEN / 8;
  localparam int OFS = $clog2(NB);
  localparam int AW  = ADDR_W - OFS;
  localparam int CW  = 2;

  localparam logic [1:0] ERR_NONE  = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_F3    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCESS = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3,
    S_ERR    = 3'd4
  } state_t;

  state_t state;
  state_t next_state;

  // Request fields kept for the duration of the access.
  logic             wr_q;
  logic [2:0]       f3_q;
  logic [OFS-1:0]   off_q;
  logic [1:0]       err_q;
  logic [CW-1:0]    cnt_q;

  // Next values of the registered outputs.
  logic             oe_d;
  logic [NB-1:0]    web_d;
  logic [AW-1:0]    a_d;
  logic [XLEN-1:0]  di_d;
  logic             resp_valid_d;
  logic [XLEN-1:0]  rdata_d;
  logic [1:0]       err_d;
  logic [CW-1:0]    cnt_d;

  logic             accept;
  logic [OFS-1:0]   req_off;
  logic             req_legal;
  logic             req_mis;
  logic             req_ok;

  // funct3 legality for the configured XLEN.
  function automatic logic f3_legal(input logic wr, input logic [2:0] f3);
    logic ok;
    if (wr) begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           ((XLEN == 64) && (f3 == 3'b011));
    end else begin
      ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
           (f3 == 3'b100) || (f3 == 3'b101) ||
           ((XLEN == 64) && ((f3 == 3'b011) || (f3 == 3'b110)));
    end
    return ok;
  endfunction

  // An access is misaligned when any offset bit below its size is set.
  function automatic logic misaligned(input logic [2:0] f3, input logic [OFS-1:0] off);
    logic [OFS-1:0] low_mask;
    low_mask = OFS'((4'd1 << f3[1:0]) - 4'd1);
    return |(off & low_mask);
  endfunction

  // Byte lanes touched by an aligned access of 2^f3[1:0] bytes at lane off.
  function automatic logic [NB-1:0] lane_mask(input logic [2:0] f3, input logic [OFS-1:0] off);
    int            size;
    logic [NB-1:0] ones;
    size = 1 << f3[1:0];
    if (size > NB) size = NB;
    ones = {NB{1'b1}} >> (NB - size);
    return ones << off;
  endfunction

  // Move the addressed bytes down to bit 0, then sign- or zero-extend.
  // funct3[2] set selects the unsigned variants.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] raw,
                                                  input logic [OFS-1:0]  off,
                                                  input logic [2:0]      f3);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] keep;
    logic [XLEN-1:0] sign_bit;
    logic            fill;
    int              nbits;
    sh    = raw >> {off, 3'b000};
    nbits = 8 << f3[1:0];
    if (nbits > XLEN) nbits = XLEN;
    keep     = {XLEN{1'b1}} >> (XLEN - nbits);
    sign_bit = keep & ~(keep >> 1);
    fill     = ~f3[2] & (|(sh & sign_bit));
    return (sh & keep) | ({XLEN{fill}} & ~keep);
  endfunction

  assign req_ready = (state == S_IDLE);
  assign accept    = req_valid && req_ready;
  assign req_off   = req_addr[OFS-1:0];
  assign req_legal = f3_legal(req_write, req_funct3);
  assign req_mis   = misaligned(req_funct3, req_off);
  assign req_ok    = req_legal && !req_mis;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Next-state logic; an illegal funct3 outranks a misaligned address.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (accept) next_state = req_ok ? S_ACCESS : S_ERR;
      end
      S_ACCESS: begin
        if (wr_q || (RD_LAT == 1)) next_state = S_RESP;
        else                       next_state = S_WAIT;
      end
      S_WAIT: begin
        // The counter reaches 0 on the edge that leaves WAIT.
        if (cnt_q == CW'(1)) next_state = S_RESP;
      end
      S_RESP:  next_state = S_IDLE;
      S_ERR:   next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic: next values for every registered SRAM-side and response output.
  always_comb begin
    oe_d         = 1'b0;
    web_d        = {NB{1'b1}};
    a_d          = A_dm;
    di_d         = DI_dm;
    resp_valid_d = 1'b0;
    rdata_d      = '0;
    err_d        = ERR_NONE;
    cnt_d        = cnt_q;
    case (state)
      S_IDLE: begin
        if (accept && req_ok) begin
          a_d = req_addr[ADDR_W-1:OFS];
          if (req_write) begin
            web_d = ~lane_mask(req_funct3, req_off);
            di_d  = req_wdata << {req_off, 3'b000};
          end else begin
            oe_d = 1'b1;
          end
        end
      end
      S_ACCESS: begin
        if (wr_q) begin
          resp_valid_d = 1'b1;
        end else begin
          cnt_d = CW'(RD_LAT - 1);
          if (RD_LAT == 1) begin
            rdata_d      = load_extend(DO_dm, off_q, f3_q);
            resp_valid_d = 1'b1;
          end else begin
            oe_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          rdata_d      = load_extend(DO_dm, off_q, f3_q);
          resp_valid_d = 1'b1;
        end else begin
          oe_d = 1'b1;
        end
      end
      S_ERR: begin
        resp_valid_d = 1'b1;
        err_d        = err_q;
      end
      default: begin
      end
    endcase
  end

  // Registered outputs and the read-latency counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OE_dm      <= 1'b0;
      WEB_dm     <= {NB{1'b1}};
      A_dm       <= '0;
      DI_dm      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= ERR_NONE;
      cnt_q      <= '0;
    end else begin
      OE_dm      <= oe_d;
      WEB_dm     <= web_d;
      A_dm       <= a_d;
      DI_dm      <= di_d;
      resp_valid <= resp_valid_d;
      resp_rdata <= rdata_d;
      resp_err   <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  // Capture the request on acceptance; the write data goes straight into DI_dm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= 1'b0;
      f3_q  <= 3'b000;
      off_q <= '0;
      err_q <= ERR_NONE;
    end else if (accept) begin
      wr_q  <= req_write;
      f3_q  <= req_funct3;
      off_q <= req_off;
      err_q <= !req_legal ? ERR_F3 : (req_mis ? ERR_ALIGN : ERR_NONE);
    end
  end

endmodule
